uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
Shares one UART transmitter (115200 baud, 8N1, 50 MHz) between two byte-stream requesters. Arbitration is round-robin with message locking: a granted channel keeps the transmitter until it marks a byte as last. The block sequences the transmitter byte by byte using a start/busy handshake, inserts an optional idle gap between frames, and flags a transmitter that never responds.

Parameters:
GAP_CLKS, 0, idle clocks inserted after tx_busy falls before the next arbitration (0 to 65535)
TIMEOUT_CLKS, 8, maximum clocks allowed from tx_start until tx_busy is seen high (1 to 255)

Ports:
clk_50M  in  1  system clock, 50 MHz
rst_n  in  1  asynchronous active-low reset
ch0_valid  in  1  requester 0 has a byte
ch0_data  in  8  requester 0 byte
ch0_last  in  1  byte ends requester 0 message
ch0_ready  out  1  byte accepted from requester 0
ch1_valid  in  1  requester 1 has a byte
ch1_data  in  8  requester 1 byte
ch1_last  in  1  byte ends requester 1 message
ch1_ready  out  1  byte accepted from requester 1
tx_data  out  8  byte presented to the transmitter
tx_start  out  1  one-cycle launch pulse
tx_busy  in  1  transmitter frame in progress
grant_id  out  1  channel owning the current or last byte
busy  out  1  FSM not in IDLE
err_timeout  out  1  one-cycle pulse on transmitter timeout

Behaviour:
- Reset (asynchronous, any state, including mid-frame) clears:
  - all outputs to 0;
  - FSM to IDLE; lock to 0; prio to 0; gap and timeout counters to 0.
- Handshake: requester holds valid, data and last stable until it sees ready. Transfer happens on the cycle where valid and ready are both high. ready is registered and is high for exactly one cycle per accepted byte.
- FSM states: IDLE, GRANT, START, WAIT_HI, WAIT_LO, GAP.
- IDLE:
  - If lock=1, only the owner channel is eligible; otherwise both are.
  - If any eligible valid is high: select a channel and go to GRANT.
  - Both valid and unlocked: pick ch(prio).
- GRANT:
  - Assert chX_ready.
  - Latch data into tx_data and latch last; set grant_id.
  - Go to START.
- START: tx_start=1 for this cycle only; clear timeout counter; go to WAIT_HI.
- WAIT_HI:
  - tx_busy=1 -> WAIT_LO.
  - Counter reaches TIMEOUT_CLKS -> pulse err_timeout, clear lock, set prio=~grant_id, go to IDLE. The byte is dropped and not retried.
- WAIT_LO: tx_busy=0 -> GAP if GAP_CLKS>0, else IDLE.
- GAP: count GAP_CLKS cycles, then go to IDLE.
- Lock and priority updates, on acceptance in GRANT:
  - last=0 -> lock=1, owner=grant_id.
  - last=1 -> lock=0, prio=~grant_id.
- Locked starvation is intended: while locked, the other channel waits indefinitely, even if the owner's valid is low.
- Latency: valid high in IDLE at edge n -> ready high after edge n+1 -> tx_start high after edge n+2, with tx_data already valid.
- tx_data holds its value until the next GRANT.
- Simultaneous events:
  - tx_busy rising in the same cycle the timeout counter expires counts as success (WAIT_LO), no err_timeout.
  - New valid arriving during WAIT_*/GAP is ignored until IDLE.
- At 115200 baud a frame is 4340 clocks. The arbiter imposes no baud timing itself; all frame timing is taken from tx_busy.

Test Plan:
1. Single byte: ch0_valid=1, data=0x63, last=1, transmitter model busy 4340 clocks -> ch0_ready 1 cycle; tx_start 2 clocks after valid; tx_data=0x63; serial line 0,1,1,0,0,0,1,1,0,1 (LSB first), 8.68 us per bit; ch0_ready not reasserted until next valid.
2. Contention round-robin: both channels continuously valid, every byte last=1, 6 bytes -> grant order 0,1,0,1,0,1; no byte duplicated or lost.
3. Message lock: ch0 sends 0x41,0x42,0x43 (last only on 0x43) while ch1 valid throughout -> ch1 not granted until after 0x43 frame; then ch1 granted next.
4. Timeout: tx_busy tied 0, ch1 sends 0x55 -> err_timeout single pulse 8 clocks after tx_start; FSM IDLE; lock cleared; busy=0.
5. Gap: GAP_CLKS=100, two back-to-back ch0 bytes -> second tx_start exactly 100+2 clocks after tx_busy falls; timeout/busy-rise coincidence cycle -> no error.
6. Reset mid-frame: assert rst_n=0 during WAIT_LO with lock=1 -> all outputs 0 immediately (asynchronous); after release, ch1 alone is granted first.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one byte-wide UART transmitter between two requesters. Arbitration
// is round-robin, with message locking: once a channel is granted a byte
// whose last flag is low, only that channel is served until it sends a byte
// with last high. Each byte is handed to the transmitter with a one-cycle
// tx_start pulse. The arbiter then follows tx_busy (rise, then fall), adds an
// optional idle gap, and reports a transmitter that never raises tx_busy.
// The arbiter does no baud timing of its own; tx_busy sets the frame length.
//
// Parameters
//   GAP_CLKS     idle clocks between the clock edge that first samples
//                tx_busy low and the next arbitration edge (0..65535).
//   TIMEOUT_CLKS clocks allowed from tx_start until tx_busy is seen high
//                (1..255).
//
// Ports
//   clk_50M      in   system clock
//   rst_n        in   asynchronous active-low reset
//   ch0_valid    in   requester 0 has a byte
//   ch0_data     in   requester 0 byte [7:0]
//   ch0_last     in   byte ends requester 0 message
//   ch0_ready    out  one-cycle accept strobe for requester 0
//   ch1_valid    in   requester 1 has a byte
//   ch1_data     in   requester 1 byte [7:0]
//   ch1_last     in   byte ends requester 1 message
//   ch1_ready    out  one-cycle accept strobe for requester 1
//   tx_data      out  byte presented to the transmitter [7:0]
//   tx_start     out  one-cycle launch pulse
//   tx_busy      in   transmitter frame in progress
//   grant_id     out  channel owning the current or last byte
//   busy         out  arbiter FSM not idle
//   err_timeout  out  one-cycle pulse when tx_busy never rose
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int unsigned GAP_CLKS     = 0,
  parameter int unsigned TIMEOUT_CLKS = 8
) (
  input  logic       clk_50M,
  input  logic       rst_n,
  input  logic       ch0_valid,
  input  logic [7:0] ch0_data,
  input  logic       ch0_last,
  output logic       ch0_ready,
  input  logic       ch1_valid,
  input  logic [7:0] ch1_data,
  input  logic       ch1_last,
  output logic       ch1_ready,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic       grant_id,
  output logic       busy,
  output logic       err_timeout
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GRANT   = 3'd1,
    S_START   = 3'd2,
    S_WAIT_HI = 3'd3,
    S_WAIT_LO = 3'd4,
    S_GAP     = 3'd5
  } state_t;

  // The IDLE arbitration clock is itself the last idle clock of the gap, so
  // the GAP state only has to run GAP_CLKS-1 cycles. With GAP_CLKS of 0 or 1
  // the single IDLE cycle already provides the spacing and GAP is skipped.
  localparam bit          GAP_EN   = (GAP_CLKS > 1);
  localparam logic [15:0] GAP_LAST = GAP_EN ? 16'(GAP_CLKS - 2) : 16'd0;
  localparam logic [7:0]  TO_LAST  = 8'(TIMEOUT_CLKS - 1);

  state_t      r_state;
  logic        r_lock;      // a message is in progress
  logic        r_owner;     // channel holding the lock
  logic        r_prio;      // preferred channel when both request unlocked
  logic        r_sel;       // channel chosen in IDLE, served in GRANT
  logic [7:0]  r_to_cnt;
  logic [15:0] r_gap_cnt;

  logic        r_ch0_ready;
  logic        r_ch1_ready;
  logic [7:0]  r_tx_data;
  logic        r_tx_start;
  logic        r_grant_id;
  logic        r_err;

  logic        w_req0;
  logic        w_req1;
  logic        w_pick;
  logic [7:0]  w_sel_data;
  logic        w_sel_last;

  // While locked only the owner may be served; the other channel waits even
  // if the owner has nothing to send right now.
  assign w_req0 = ch0_valid && (!r_lock || (r_owner == 1'b0));
  assign w_req1 = ch1_valid && (!r_lock || (r_owner == 1'b1));
  assign w_pick = (w_req0 && w_req1) ? r_prio : w_req1;

  assign w_sel_data = r_sel ? ch1_data : ch0_data;
  assign w_sel_last = r_sel ? ch1_last : ch0_last;

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_lock      <= 1'b0;
      r_owner     <= 1'b0;
      r_prio      <= 1'b0;
      r_sel       <= 1'b0;
      r_to_cnt    <= 8'd0;
      r_gap_cnt   <= 16'd0;
      r_ch0_ready <= 1'b0;
      r_ch1_ready <= 1'b0;
      r_tx_data   <= 8'd0;
      r_tx_start  <= 1'b0;
      r_grant_id  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      // Strobes default low so each is high for a single cycle only.
      r_ch0_ready <= 1'b0;
      r_ch1_ready <= 1'b0;
      r_tx_start  <= 1'b0;
      r_err       <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_req0 || w_req1) begin
            r_sel   <= w_pick;
            r_state <= S_GRANT;
          end
        end

        S_GRANT: begin
          // The requester holds data stable until it sees ready, so the
          // byte can be captured on the same edge that raises ready.
          r_ch0_ready <= (r_sel == 1'b0);
          r_ch1_ready <= (r_sel == 1'b1);
          r_tx_data   <= w_sel_data;
          r_grant_id  <= r_sel;
          if (w_sel_last) begin
            r_lock <= 1'b0;
            r_prio <= ~r_sel;
          end else begin
            r_lock  <= 1'b1;
            r_owner <= r_sel;
          end
          r_state <= S_START;
        end

        S_START: begin
          r_tx_start <= 1'b1;
          r_to_cnt   <= 8'd0;
          r_state    <= S_WAIT_HI;
        end

        S_WAIT_HI: begin
          // tx_busy is checked first: a rise on the expiry edge is a success.
          if (tx_busy) begin
            r_state <= S_WAIT_LO;
          end else if (r_to_cnt == TO_LAST) begin
            // Byte is dropped; the message is abandoned and the other
            // channel is favoured next.
            r_err   <= 1'b1;
            r_lock  <= 1'b0;
            r_prio  <= ~r_grant_id;
            r_state <= S_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 8'd1;
          end
        end

        S_WAIT_LO: begin
          if (!tx_busy) begin
            r_gap_cnt <= 16'd0;
            r_state   <= GAP_EN ? S_GAP : S_IDLE;
          end
        end

        S_GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_state <= S_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + 16'd1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ch0_ready   = r_ch0_ready;
  assign ch1_ready   = r_ch1_ready;
  assign tx_data     = r_tx_data;
  assign tx_start    = r_tx_start;
  assign grant_id    = r_grant_id;
  assign err_timeout = r_err;
  assign busy        = (r_state != S_IDLE);

endmodule
